// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner.
//   scanState_t  : debounce state machine encodings
//   frameClass_t : result of classifying one complete scan frame
//   satAdd2      : key-count adder that saturates at 2 ("two or more")
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } scanState_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } frameClass_t;

  // Only "zero, one, more than one" matters for ghost rejection, so counts
  // are clamped at 2.
  function automatic logic [1:0] satAdd2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Width-parametrised two-flop synchroniser.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d_i : asynchronous input bus
//   q_o : synchronised output, two clk cycles of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with frame-level debounce and ghost rejection.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   fila      : row lines, active-high, asynchronous to clk
//   col       : one-hot column strobes, active-high
//   key_code  : row*COLS + col of the reported key
//   key_valid : event pending, held until accepted
//   key_ready : consumer accepts when key_valid && key_ready
//   key_held  : a debounced key is currently down
//   overrun   : sticky, an event was dropped while key_valid was stuck
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS-1:0]                fila,
  output logic [COLS-1:0]                col,
  output logic [$clog2(ROWS*COLS)-1:0]   key_code,
  output logic                           key_valid,
  input  logic                           key_ready,
  output logic                           key_held,
  output logic                           overrun
);

  localparam int CODE_W = $clog2(ROWS*COLS);
  localparam int DWW    = $clog2(DWELL);
  localparam int COLW   = $clog2(COLS);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [ROWS-1:0]   filaSync;

  logic [DWW-1:0]    dwellCnt_q, dwellCnt_d;
  logic [COLW-1:0]   colIdx_q, colIdx_d;
  logic [COLS-1:0]   colOh_q, colOh_d;
  logic              lastDwell, frameEnd;

  logic [1:0]        colCnt;
  logic [CODE_W-1:0] colCode;
  logic [1:0]        accCnt_q, accCnt_d;
  logic [CODE_W-1:0] accCode_q, accCode_d;
  logic [1:0]        totalCnt;
  logic [CODE_W-1:0] frameCode;
  frameClass_t       frameCls;

  scanState_t        state_q;
  logic [CODE_W-1:0] cand_q;
  logic [3:0]        dbCnt_q;
  logic [3:0]        dbNext;

  logic              raiseEvt;
  logic              accept;
  logic              keyValid_q;
  logic [CODE_W-1:0] keyCode_q;
  logic              overrun_q;

  sync_2ff #(.WIDTH(ROWS)) u_filaSync (
    .clk (clk),
    .rst (rst),
    .d_i (fila),
    .q_o (filaSync)
  );

  // Column sequencer: each column is driven for DWELL cycles, then the
  // strobe advances and wraps after the last column.
  always_comb begin
    lastDwell  = (dwellCnt_q == DWW'(DWELL - 1));
    frameEnd   = lastDwell && (colIdx_q == COLW'(COLS - 1));
    dwellCnt_d = lastDwell ? '0 : dwellCnt_q + DWW'(1);
    colIdx_d   = colIdx_q;
    if (lastDwell) begin
      colIdx_d = (colIdx_q == COLW'(COLS - 1)) ? '0 : colIdx_q + COLW'(1);
    end
    colOh_d = COLS'(1) << colIdx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwellCnt_q <= '0;
      colIdx_q   <= '0;
      colOh_q    <= COLS'(1);
    end else begin
      dwellCnt_q <= dwellCnt_d;
      colIdx_q   <= colIdx_d;
      colOh_q    <= colOh_d;
    end
  end

  // Rows seen in the current column: count (clamped at 2) and the code of
  // the hit row, which is only meaningful when exactly one row is active.
  always_comb begin
    colCnt  = 2'd0;
    colCode = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (filaSync[r]) begin
        colCode = CODE_W'(r * COLS) + CODE_W'(colIdx_q);
        if (colCnt != 2'd2) begin
          colCnt = colCnt + 2'd1;
        end
      end
    end
  end

  // Combine this column with the earlier columns of the frame. At frame end
  // the combined result is the frame's classification.
  always_comb begin
    totalCnt  = satAdd2(accCnt_q, colCnt);
    frameCode = (accCnt_q != 2'd0) ? accCode_q : colCode;
    case (totalCnt)
      2'd0:    frameCls = NONE;
      2'd1:    frameCls = ONE;
      default: frameCls = MULTI;
    endcase
    accCnt_d  = accCnt_q;
    accCode_d = accCode_q;
    if (frameEnd) begin
      accCnt_d  = 2'd0;
      accCode_d = '0;
    end else if (lastDwell) begin
      accCnt_d  = totalCnt;
      accCode_d = frameCode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accCnt_q  <= 2'd0;
      accCode_q <= '0;
    end else begin
      accCnt_q  <= accCnt_d;
      accCode_q <= accCode_d;
    end
  end

  // A press event fires on the frame end that completes the debounce run,
  // including the single-frame case where IDLE or a candidate switch goes
  // straight to HELD.
  always_comb begin
    dbNext   = dbCnt_q + 4'd1;
    raiseEvt = 1'b0;
    if (frameEnd && (frameCls == ONE)) begin
      case (state_q)
        IDLE:       raiseEvt = (DB == 4'd1);
        PRESS_PEND: raiseEvt = (frameCode == cand_q) ? (dbNext >= DB) : (DB == 4'd1);
        default:    raiseEvt = 1'b0;
      endcase
    end
  end

  // Debounce state machine, advanced only at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      dbCnt_q <= 4'd0;
    end else if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (frameCls == ONE) begin
            cand_q  <= frameCode;
            dbCnt_q <= 4'd1;
            state_q <= raiseEvt ? HELD : PRESS_PEND;
          end
        end
        PRESS_PEND: begin
          if (frameCls == ONE) begin
            if (raiseEvt) begin
              cand_q  <= frameCode;
              state_q <= HELD;
            end else if (frameCode == cand_q) begin
              dbCnt_q <= dbNext;
            end else begin
              cand_q  <= frameCode;
              dbCnt_q <= 4'd1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        HELD: begin
          if (frameCls == NONE) begin
            dbCnt_q <= 4'd1;
            state_q <= (DB == 4'd1) ? IDLE : RELEASE_PEND;
          end
        end
        RELEASE_PEND: begin
          if (frameCls == NONE) begin
            if (dbNext >= DB) begin
              state_q <= IDLE;
            end else begin
              dbCnt_q <= dbNext;
            end
          end else begin
            state_q <= HELD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Event handshake: a new event loads when the slot is empty or being
  // accepted this cycle; otherwise it is dropped and overrun latches.
  always_comb begin
    accept = keyValid_q && key_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyValid_q <= 1'b0;
      keyCode_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (accept) begin
        overrun_q <= 1'b0;
      end
      if (raiseEvt) begin
        if (!keyValid_q || key_ready) begin
          keyValid_q <= 1'b1;
          keyCode_q  <= frameCode;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (accept) begin
        keyValid_q <= 1'b0;
      end
    end
  end

  assign col       = colOh_q;
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign overrun   = overrun_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE_PEND);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, DWELL=4, DEBOUNCE=3). A pressed-key
// set drives fila from the column strobes; cycle numbers count from the
// release of reset, one frame being 16 cycles.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyReady;
  logic        keyHeld;
  logic        overrunO;
  logic [15:0] pressedKeys;

  int testsRun;
  int testsFailed;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fila      (fila),
    .col       (col),
    .key_code  (keyCode),
    .key_valid (keyValid),
    .key_ready (keyReady),
    .key_held  (keyHeld),
    .overrun   (overrunO)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ideal keypad: a row reads high when its pressed key sits in the strobed column.
  always_comb begin
    fila = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col[c] && pressedKeys[r*4+c]) fila[r] = 1'b1;
      end
    end
  end

  // Leaves the bench at the falling edge of cycle 0 with reset released.
  task automatic doReset();
    rst = 1'b1;
    pressedKeys = '0;
    keyReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if (col !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_col got %b want 0001", col); end
    testsRun++;
    if (keyCode !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_code got %0d want 0", keyCode); end
    testsRun++;
    if (keyValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", keyValid); end
    testsRun++;
    if (keyHeld !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_held got %b want 0", keyHeld); end
    testsRun++;
    if (overrunO !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overrun got %b want 0", overrunO); end
  endtask

  task automatic test_scan_wrap();
    logic [3:0] expCol;
    doReset();
    for (int c = 0; c < 40; c++) begin
      expCol = 4'b0001 << ((c / 4) % 4);
      testsRun++;
      if (col !== expCol) begin testsFailed++; $display("[TB] FAIL scan_col cycle %0d got %b want %b", c, col, expCol); end
      testsRun++;
      if (keyValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL scan_valid cycle %0d got %b want 0", c, keyValid); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    doReset();
    keyReady = 1'b1;
    for (int c = 0; c <= 135; c++) begin
      if (c == 0)  pressedKeys[9] = 1'b1;
      if (c == 80) pressedKeys[9] = 1'b0;
      testsRun++;
      if (keyValid !== (c == 48)) begin testsFailed++; $display("[TB] FAIL press_valid cycle %0d got %b want %b", c, keyValid, (c == 48)); end
      testsRun++;
      if (keyHeld !== (c >= 48 && c <= 127)) begin testsFailed++; $display("[TB] FAIL press_held cycle %0d got %b want %b", c, keyHeld, (c >= 48 && c <= 127)); end
      if (c == 48) begin
        testsRun++;
        if (keyCode !== 4'd9) begin testsFailed++; $display("[TB] FAIL press_code got %0d want 9", keyCode); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bounce();
    int f;
    doReset();
    keyReady = 1'b1;
    for (int c = 0; c <= 127; c++) begin
      f = c / 16;
      if (c % 16 == 0) pressedKeys[6] = (f == 0 || f == 1 || f == 3 || f == 4);
      testsRun++;
      if (keyValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bounce_valid cycle %0d got %b want 0", c, keyValid); end
      testsRun++;
      if (keyHeld !== 1'b0) begin testsFailed++; $display("[TB] FAIL bounce_held cycle %0d got %b want 0", c, keyHeld); end
      @(negedge clk);
    end
  endtask

  task automatic test_ghost();
    doReset();
    keyReady = 1'b1;
    for (int c = 0; c <= 120; c++) begin
      if (c == 0)  begin pressedKeys[0] = 1'b1; pressedKeys[5] = 1'b1; end
      if (c == 64) pressedKeys[5] = 1'b0;
      testsRun++;
      if (keyValid !== (c == 112)) begin testsFailed++; $display("[TB] FAIL ghost_valid cycle %0d got %b want %b", c, keyValid, (c == 112)); end
      testsRun++;
      if (keyHeld !== (c >= 112)) begin testsFailed++; $display("[TB] FAIL ghost_held cycle %0d got %b want %b", c, keyHeld, (c >= 112)); end
      if (c == 112) begin
        testsRun++;
        if (keyCode !== 4'd0) begin testsFailed++; $display("[TB] FAIL ghost_code got %0d want 0", keyCode); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    doReset();
    keyReady = 1'b0;
    for (int c = 0; c <= 150; c++) begin
      if (c == 0)  pressedKeys[3]  = 1'b1;
      if (c == 48) pressedKeys[3]  = 1'b0;
      if (c == 96) pressedKeys[12] = 1'b1;
      if (c == 144) pressedKeys[12] = 1'b0;
      if (c == 48 || c == 144 || c == 150) begin
        testsRun++;
        if (keyValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_valid cycle %0d got %b want 1", c, keyValid); end
        testsRun++;
        if (keyCode !== 4'd3) begin testsFailed++; $display("[TB] FAIL bp_code cycle %0d got %0d want 3", c, keyCode); end
      end
      if (c == 143) begin
        testsRun++;
        if (overrunO !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_overrun_early got %b want 0", overrunO); end
      end
      if (c == 144 || c == 150) begin
        testsRun++;
        if (overrunO !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_overrun cycle %0d got %b want 1", c, overrunO); end
      end
      if (c == 150) keyReady = 1'b1;
      @(negedge clk);
    end
    keyReady = 1'b0;
    testsRun++;
    if (keyValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_accept_valid got %b want 0", keyValid); end
    testsRun++;
    if (overrunO !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_accept_overrun got %b want 0", overrunO); end
  endtask

  task automatic test_reset_mid_hold();
    doReset();
    keyReady = 1'b0;
    pressedKeys[9] = 1'b1;
    repeat (50) @(negedge clk);
    testsRun++;
    if (keyValid !== 1'b1 || keyHeld !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midhold_pre valid=%b held=%b want 1/1", keyValid, keyHeld);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (col !== 4'b0001 || keyValid !== 1'b0 || keyHeld !== 1'b0 || overrunO !== 1'b0 || keyCode !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL midhold_async col=%b valid=%b held=%b ovr=%b code=%0d want 0001/0/0/0/0",
               col, keyValid, keyHeld, overrunO, keyCode);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      testsRun++;
      if (keyValid !== (c >= 48)) begin testsFailed++; $display("[TB] FAIL midhold_valid cycle %0d got %b want %b", c, keyValid, (c >= 48)); end
      if (c == 48) begin
        testsRun++;
        if (keyCode !== 4'd9) begin testsFailed++; $display("[TB] FAIL midhold_code got %0d want 9", keyCode); end
      end
      @(negedge clk);
    end
  endtask

  // Scenario sequence; every scenario starts from its own reset.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    keyReady = 1'b0;
    pressedKeys = '0;
    test_reset();
    test_scan_wrap();
    test_single_press();
    test_bounce();
    test_ghost();
    test_backpressure();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
